// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM request arbiter.
package ram_arb_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} arb_state_t;
   typedef enum logic {ARB_ID_I, ARB_ID_D} arb_id_t;
endpackage

// File: rtl/rv32i_types_pkg.sv
// Core-wide RV32I types shared by the memory subsystem.
package rv32i_types_pkg;
   localparam int unsigned RAM_ADDR_SIZE = 16;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/ram_if.sv
// RAM request/response bundle; 'cpu' drives requests, 'ram' answers them.
interface ram_if;
   import rv32i_types_pkg::*;

   logic [RAM_ADDR_SIZE-1:0] addr;
   word_t                    wdata;
   logic                     ren;
   logic                     wen;
   logic [3:0]               byte_en;
   word_t                    rdata;
   logic                     busy;

   modport ram (input addr, wdata, ren, wen, byte_en, output rdata, busy);
   modport cpu (output addr, wdata, ren, wen, byte_en, input rdata, busy);
endinterface

// File: rtl/ram_req_arbiter.sv
// Two-to-one arbiter between instruction fetch and data requestors in front of the RAM.
// A grant is held until the RAM drops busy or the granted requestor withdraws.
module ram_req_arbiter
   import ram_arb_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input logic CLK,
   input logic nRST,
   ram_if.ram  iram,
   ram_if.ram  dram,
   ram_if.cpu  ram
);

   arb_state_t state_q, state_d;
   arb_id_t    last_grant_q, last_grant_d;
   logic       req_i, req_d;

   assign req_i = iram.ren | iram.wen;
   assign req_d = dram.ren | dram.wen;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= ARB_ID_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (req_i && req_d) begin
               state_d = (ROUND_ROBIN && (last_grant_q == ARB_ID_D)) ? ARB_GRANT_I : ARB_GRANT_D;
            end else if (req_d) begin
               state_d = ARB_GRANT_D;
            end else if (req_i) begin
               state_d = ARB_GRANT_I;
            end
         end
         // The completing requestor's own request is stale; only the other side is considered.
         ARB_GRANT_I: begin
            if (!req_i) begin
               state_d = ARB_IDLE;
            end else if (!ram.busy) begin
               state_d = req_d ? ARB_GRANT_D : ARB_IDLE;
            end
         end
         ARB_GRANT_D: begin
            if (!req_d) begin
               state_d = ARB_IDLE;
            end else if (!ram.busy) begin
               state_d = req_i ? ARB_GRANT_I : ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      if ((state_d == ARB_GRANT_I) && (state_q != ARB_GRANT_I)) begin
         last_grant_d = ARB_ID_I;
      end else if ((state_d == ARB_GRANT_D) && (state_q != ARB_GRANT_D)) begin
         last_grant_d = ARB_ID_D;
      end
   end

   always_comb begin
      ram.addr    = '0;
      ram.wdata   = '0;
      ram.ren     = 1'b0;
      ram.wen     = 1'b0;
      ram.byte_en = '0;
      iram.busy   = 1'b1;
      iram.rdata  = '0;
      dram.busy   = 1'b1;
      dram.rdata  = '0;
      unique case (state_q)
         ARB_GRANT_I: begin
            ram.addr    = iram.addr;
            ram.wdata   = iram.wdata;
            ram.ren     = iram.ren;
            ram.wen     = iram.wen;
            ram.byte_en = iram.byte_en;
            iram.busy   = ram.busy;
            iram.rdata  = ram.rdata;
         end
         ARB_GRANT_D: begin
            ram.addr    = dram.addr;
            ram.wdata   = dram.wdata;
            ram.ren     = dram.ren;
            ram.wen     = dram.wen;
            ram.byte_en = dram.byte_en;
            dram.busy   = ram.busy;
            dram.rdata  = ram.rdata;
         end
         default: ;
      endcase
   end

endmodule
